// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - match-level sequencer for the pong datapath
//
// Orders the game phases IDLE -> SERVE -> PLAY (pausable) -> OVER, gates ball
// motion, issues the serve pulse, selects serve direction and keeps scores.
// All phase timing is counted in frame ticks, not clocks.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   frame_tick_i    1-cycle pulse per frame (vsync rising edge)
//   start_i         start/pause key level (edge-detected internally)
//   miss_left_i     ball lost on the computer side; player scores
//   miss_right_i    ball lost on the player side; computer scores
//   ball_run_o      ball movement enable
//   serve_o         1-cycle pulse on the first PLAY cycle after SERVE
//   serve_dir_o     0 = serve toward +x (player), 1 = toward -x (computer)
//   score_player_o  player score
//   score_pc_o      computer score
//   game_over_o     high while in OVER
//   winner_o        0 = player won, 1 = computer won (valid with game_over_o)
//   state_o         IDLE=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4
module pong_match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    output logic               ball_run_o,
    output logic               serve_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] score_player_o,
    output logic [SCORE_W-1:0] score_pc_o,
    output logic               game_over_o,
    output logic               winner_o,
    output logic [2:0]         state_o
);

    localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   OVER_LAST  = CNT_W'(OVER_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_player_q, score_player_d;
    logic [SCORE_W-1:0] score_pc_q, score_pc_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               serve_q, serve_d;
    logic               ball_run_q;
    logic               game_over_q;
    logic               start_q;

    logic               start_edge;
    logic [SCORE_W-1:0] player_inc;
    logic [SCORE_W-1:0] pc_inc;

    assign start_edge = start_i & ~start_q;
    assign player_inc = score_player_q + SCORE_W'(1);
    assign pc_inc     = score_pc_q + SCORE_W'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        score_player_d = score_player_q;
        score_pc_d     = score_pc_q;
        serve_dir_d    = serve_dir_q;
        winner_d       = winner_q;
        serve_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d        = ST_SERVE;
                    cnt_d          = '0;
                    score_player_d = '0;
                    score_pc_d     = '0;
                    serve_dir_d    = 1'b0;
                end
            end

            ST_SERVE: begin
                if (frame_tick_i) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        serve_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                // A miss always wins over a pause request in the same cycle.
                if (miss_left_i && miss_right_i) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end else if (miss_left_i) begin
                    score_player_d = player_inc;
                    serve_dir_d    = 1'b1;
                    cnt_d          = '0;
                    if (player_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else if (miss_right_i) begin
                    score_pc_d  = pc_inc;
                    serve_dir_d = 1'b0;
                    cnt_d       = '0;
                    if (pc_inc == WIN_VAL) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else if (start_edge) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                end
            end

            ST_OVER: begin
                // Lockout: the counter saturates at OVER_LAST, which is
                // also the condition that re-arms the start key.
                if (start_edge && (cnt_q == OVER_LAST)) begin
                    state_d        = ST_SERVE;
                    cnt_d          = '0;
                    score_player_d = '0;
                    score_pc_d     = '0;
                    serve_dir_d    = 1'b0;
                end else if (frame_tick_i && (cnt_q != OVER_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            score_player_q <= '0;
            score_pc_q     <= '0;
            serve_dir_q    <= 1'b0;
            winner_q       <= 1'b0;
            serve_q        <= 1'b0;
            ball_run_q     <= 1'b0;
            game_over_q    <= 1'b0;
            // Held high so a key pressed through reset is not seen as an edge.
            start_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_player_q <= score_player_d;
            score_pc_q     <= score_pc_d;
            serve_dir_q    <= serve_dir_d;
            winner_q       <= winner_d;
            serve_q        <= serve_d;
            ball_run_q     <= (state_d == ST_PLAY);
            game_over_q    <= (state_d == ST_OVER);
            start_q        <= start_i;
        end
    end

    assign ball_run_o     = ball_run_q;
    assign serve_o        = serve_q;
    assign serve_dir_o    = serve_dir_q;
    assign score_player_o = score_player_q;
    assign score_pc_o     = score_pc_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 9;
    localparam int SERVE_FRAMES = 60;
    localparam int OVER_FRAMES  = 180;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_PAUSE = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i        = 1'b1;
    logic               frame_tick_i = 1'b0;
    logic               start_i      = 1'b1;
    logic               miss_left_i  = 1'b0;
    logic               miss_right_i = 1'b0;
    logic               ball_run_o;
    logic               serve_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] score_player_o;
    logic [SCORE_W-1:0] score_pc_o;
    logic               game_over_o;
    logic               winner_o;
    logic [2:0]         state_o;

    pong_match_ctrl #(
        .SCORE_W      (SCORE_W),
        .WIN_SCORE    (WIN_SCORE),
        .SERVE_FRAMES (SERVE_FRAMES),
        .OVER_FRAMES  (OVER_FRAMES)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .frame_tick_i   (frame_tick_i),
        .start_i        (start_i),
        .miss_left_i    (miss_left_i),
        .miss_right_i   (miss_right_i),
        .ball_run_o     (ball_run_o),
        .serve_o        (serve_o),
        .serve_dir_o    (serve_dir_o),
        .score_player_o (score_player_o),
        .score_pc_o     (score_pc_o),
        .game_over_o    (game_over_o),
        .winner_o       (winner_o),
        .state_o        (state_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: game phase plus frames elapsed in the current timed phase.
    int m_phase      = PH_IDLE;
    int m_frames     = 0;
    int m_player     = 0;
    int m_pc         = 0;
    bit m_dir        = 1'b0;
    bit m_winner     = 1'b0;
    bit m_serve      = 1'b0;
    bit m_prev_start = 1'b1;
    bit cur_start    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void award(input bit to_player);
        if (to_player) begin
            m_player++;
            m_dir = 1'b1;
        end else begin
            m_pc++;
            m_dir = 1'b0;
        end
        m_frames = 0;
        if ((to_player ? m_player : m_pc) == WIN_SCORE) begin
            m_phase  = PH_OVER;
            m_winner = !to_player;
        end else begin
            m_phase = PH_SERVE;
        end
    endfunction

    function automatic void new_match();
        m_phase  = PH_SERVE;
        m_frames = 0;
        m_player = 0;
        m_pc     = 0;
        m_dir    = 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit t, input bit l, input bit m);
        bit pressed;
        if (r) begin
            m_phase = PH_IDLE; m_frames = 0; m_player = 0; m_pc = 0;
            m_dir = 1'b0; m_winner = 1'b0; m_serve = 1'b0; m_prev_start = 1'b1;
            return;
        end
        pressed      = s && !m_prev_start;
        m_prev_start = s;
        m_serve      = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (pressed) new_match();
        end else if (m_phase == PH_SERVE) begin
            if (t) begin
                m_frames++;
                if (m_frames == SERVE_FRAMES) begin
                    m_phase  = PH_PLAY;
                    m_frames = 0;
                    m_serve  = 1'b1;
                end
            end
        end else if (m_phase == PH_PLAY) begin
            if (l && m) begin
                m_phase  = PH_SERVE;
                m_frames = 0;
            end else if (l) begin
                award(1'b1);
            end else if (m) begin
                award(1'b0);
            end else if (pressed) begin
                m_phase = PH_PAUSE;
            end
        end else if (m_phase == PH_PAUSE) begin
            if (pressed) m_phase = PH_PLAY;
        end else begin
            if (pressed && m_frames >= OVER_FRAMES) new_match();
            else if (t && m_frames < OVER_FRAMES) m_frames++;
        end
    endfunction

    task automatic step(input bit r, input bit s, input bit t, input bit l, input bit m);
        @(negedge clk);
        rst_i = r; start_i = s; frame_tick_i = t; miss_left_i = l; miss_right_i = m;
        @(posedge clk);
        model_step(r, s, t, l, m);
        #1;
        chk("state", state_o, m_phase);
        chk("score_player", score_player_o, m_player);
        chk("score_pc", score_pc_o, m_pc);
        chk("serve_dir", serve_dir_o, m_dir);
        chk("serve", serve_o, m_serve);
        chk("ball_run", ball_run_o, (m_phase == PH_PLAY));
        chk("game_over", game_over_o, (m_phase == PH_OVER));
        if (m_phase == PH_OVER) chk("winner", winner_o, m_winner);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, cur_start, 1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 1)) step(1'b0, cur_start, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_start = 1'b0;
    endtask

    initial begin
        // Key held through and after reset: must stay idle.
        cur_start = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("held_key_idle", state_o, PH_IDLE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_start = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_to_serve", state_o, PH_SERVE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Serve delay boundary.
        run_ticks(SERVE_FRAMES - 1);
        chk("serve_not_yet", state_o, PH_SERVE);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("serve_pulse", serve_o, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("serve_pulse_gone", serve_o, 0);

        // Computer scores, then player scores.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pc_point", score_pc_o, 1);
        run_ticks(SERVE_FRAMES);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("player_dir", serve_dir_o, 1);
        run_ticks(SERVE_FRAMES);

        // Simultaneous misses, then miss with start edge.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("double_miss", state_o, PH_SERVE);
        run_ticks(SERVE_FRAMES);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("miss_beats_pause", state_o, PH_SERVE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_start = 1'b0;
        run_ticks(SERVE_FRAMES);

        // Pause and resume.
        press();
        chk("paused", state_o, PH_PAUSE);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        press();
        chk("resumed", state_o, PH_PLAY);

        // Player wins the match.
        for (int k = 0; k < 20 && m_phase != PH_OVER; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (m_phase == PH_SERVE) run_ticks(SERVE_FRAMES);
        end
        chk("over_reached", game_over_o, 1);
        chk("player_won", winner_o, 0);
        run_ticks(100);
        press();
        chk("over_lockout", state_o, PH_OVER);
        run_ticks(OVER_FRAMES - 100);
        press();
        chk("restart_serve", state_o, PH_SERVE);
        chk("restart_score", score_player_o, 0);

        // Reset mid-play.
        run_ticks(SERVE_FRAMES);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_in_play", state_o, PH_IDLE);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized play.
        for (int i = 0; i < 6000; i++) begin
            bit r, t, l, m;
            if ($urandom_range(0, 7) == 0) cur_start = ~cur_start;
            r = ($urandom_range(0, 1999) == 0);
            t = ($urandom_range(0, 1) == 0);
            l = ($urandom_range(0, 11) == 0);
            m = ($urandom_range(0, 11) == 0);
            step(r, cur_start, t, l, m);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
